// File: rtl/sm_stim_gen.sv
// Stimulus sequencer: replays a loaded vector table onto i1/i2 one vector per clock
// and counts err/o1 responses from the FSM under test.
module sm_stim_gen #(
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_data,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic             o1,
  input  logic             o2,
  input  logic             err,
  output logic             i1,
  output logic             i2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] o1_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t           state_reg, state_next;
  logic [1:0]       mem [DEPTH];
  logic [1:0]       vec_reg;
  logic [AW:0]      idx_reg, len_reg, len_eff;
  logic [CNT_W-1:0] err_cnt_reg, o1_cnt_reg;
  logic             accept, sampling;
  logic             unused_ok;

  // o2 is reserved; keep it on the port without feeding any logic
  assign unused_ok = ^{o2, 1'b0};

  assign len_eff  = (len > DEPTH_L) ? DEPTH_L : len;
  assign sampling = (state_reg == RUN) || (state_reg == FLUSH);
  assign busy     = sampling;
  assign done     = (state_reg == DONE);
  assign {i2, i1} = vec_reg;
  assign err_cnt  = err_cnt_reg;
  assign o1_cnt   = o1_cnt_reg;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (len_eff != '0)) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN:     if (idx_reg == len_reg) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Table is not reset; a start in the same cycle as a write to entry 0 replays old data
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= IDLE;
      vec_reg     <= '0;
      idx_reg     <= '0;
      len_reg     <= '0;
      err_cnt_reg <= '0;
      o1_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        vec_reg     <= mem[0];
        idx_reg     <= (AW+1)'(1);
        len_reg     <= len_eff;
        err_cnt_reg <= '0;
        o1_cnt_reg  <= '0;
      end else begin
        if ((state_reg == RUN) && (idx_reg < len_reg)) begin
          vec_reg <= mem[idx_reg[AW-1:0]];
          idx_reg <= idx_reg + 1'b1;
        end
        if (state_reg == FLUSH) vec_reg <= '0;
        // RUN and FLUSH edges each sample one response; counters saturate
        if (sampling) begin
          if (err && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + 1'b1;
          if (o1 && (o1_cnt_reg != '1))   o1_cnt_reg  <= o1_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_stim_gen.sv
// Directed bench for sm_stim_gen: scoreboard of expected vectors, plus a CNT_W=3 copy for saturation.
module tb_sm_stim_gen;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0, nrst = 1'b0;
  logic          wr_en = 1'b0, start = 1'b0, o1 = 1'b0, o2 = 1'b0, err = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [1:0]    wr_data = '0;
  logic [AW:0]   len = '0;
  logic          i1, i2, busy, done, s_i1, s_i2, s_busy, s_done;
  logic [7:0]    err_cnt, o1_cnt;
  logic [2:0]    s_err_cnt, s_o1_cnt;

  logic [1:0]    tb_mem [DEPTH];
  logic [1:0]    exp_q [$];
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  sm_stim_gen #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .o1(o1), .o2(o2), .err(err),
    .i1(i1), .i2(i2), .busy(busy), .done(done), .err_cnt(err_cnt), .o1_cnt(o1_cnt)
  );

  sm_stim_gen #(.DEPTH(DEPTH), .CNT_W(3)) dut_s (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .o1(o1), .o2(o2), .err(err),
    .i1(s_i1), .i2(s_i2), .busy(s_busy), .done(s_done), .err_cnt(s_err_cnt), .o1_cnt(s_o1_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    step();
    wr_en = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic run(input int n, input logic e, input logic o, input bit mid_start,
                     input bit mid_wr, input bit co_wr, input logic [1:0] co_data);
    int l;
    int ee, eo;
    logic [1:0] v;
    l = (n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < l; k++) exp_q.push_back(tb_mem[k]);
    len = n[AW:0]; err = e; o1 = o; start = 1'b1;
    if (co_wr) begin wr_en = 1'b1; wr_addr = '0; wr_data = co_data; end
    step();
    start = 1'b0; wr_en = 1'b0;
    if (co_wr) tb_mem[0] = co_data;
    v = 2'b00;
    for (int k = 0; k < l; k++) begin
      v = exp_q.pop_front();
      chk("vec", {i2, i1}, v);
      chk("vec_s", {s_i2, s_i1}, v);
      chk("busy_run", busy, 1'b1);
      if (mid_start && k == 1) start = 1'b1;
      if (mid_wr && k == 1) begin wr_en = 1'b1; wr_addr = '0; wr_data = ~tb_mem[0]; end
      step();
      start = 1'b0; wr_en = 1'b0;
    end
    chk("flush_vec", {i2, i1}, v);
    chk("flush_busy", busy, 1'b1);
    chk("flush_done", done, 1'b0);
    step();
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_vec", {i2, i1}, 2'b00);
    step();
    chk("done_end", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    ee = e ? l + 1 : 0;
    eo = o ? l + 1 : 0;
    chk("err_cnt", err_cnt, ee);
    chk("o1_cnt", o1_cnt, eo);
    chk("err_cnt_sat", s_err_cnt, (ee > 7) ? 7 : ee);
    chk("o1_cnt_sat", s_o1_cnt, (eo > 7) ? 7 : eo);
    $display("run len=%0d L=%0d err=%0b o1=%0b -> err_cnt=%0d o1_cnt=%0d sat_err=%0d",
             n, l, e, o, err_cnt, o1_cnt, s_err_cnt);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", {i2, i1}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_o1_cnt", o1_cnt, 8'd0);
    nrst = 1'b1;
    step();

    wr(0, 2'b01); wr(1, 2'b11); wr(2, 2'b10); wr(3, 2'b11);
    for (int a = 4; a < DEPTH; a++) wr(a, 2'($urandom_range(0, 3)));

    run(4, 1'b0, 1'b1, 0, 0, 0, 2'b00);
    run(3, 1'b1, 1'b0, 0, 0, 0, 2'b00);
    run(3, 1'b0, 1'b0, 0, 0, 0, 2'b00);

    len = '0; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_busy", busy, 1'b0);
    step();
    chk("len0_busy2", busy, 1'b0);
    chk("len0_done", done, 1'b0);
    $display("start with len=0 -> busy=%0b", busy);

    run(5, 1'b1, 1'b1, 1, 1, 0, 2'b00);
    run(5, 1'b0, 1'b0, 0, 0, 0, 2'b00);
    run(17, 1'b1, 1'b0, 0, 0, 0, 2'b00);
    run(16, 1'b1, 1'b1, 0, 0, 0, 2'b00);
    run(1, 1'b0, 1'b1, 0, 0, 1, ~tb_mem[0]);
    run(2, 1'b0, 1'b0, 0, 0, 0, 2'b00);

    len = 5'd8; err = 1'b1; o1 = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_vec", {i2, i1}, tb_mem[2]);
    chk("mid_err_cnt", err_cnt, 8'd2);
    nrst = 1'b0;
    #1;
    chk("arst_vec", {i2, i1}, 2'b00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err_cnt", err_cnt, 8'd0);
    chk("arst_o1_cnt", o1_cnt, 8'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("arst_no_done", done, 1'b0);
    end
    $display("reset mid-run -> vec=%0b%0b busy=%0b err_cnt=%0d", i2, i1, busy, err_cnt);
    nrst = 1'b1;
    step();
    run(2, 1'b1, 1'b0, 0, 0, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
